noc_out_buffer: RTL and testbench

- Clocked output-port buffer directly downstream of the 2:1 packet arbiter in the NoC router.
- Accepts one WIDTH_PACKET-bit packet per cycle on a valid/ready channel and stores it in a DEPTH-entry circular FIFO.
- Presents packets in order to the link or next-hop interface on a second valid/ready channel.
- Reports occupancy, an almost-full flag and a running count of delivered packets.

---
 rtl/noc_pkg.sv | 8 +
 rtl/noc_fifo_ctrl.sv | 80 ++++++++
 rtl/noc_out_buffer.sv | 73 +++++++
 tb/tb_noc_out_buffer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet definitions
package noc_pkg;

  localparam int WIDTH_PACKET = 57;

  typedef logic [WIDTH_PACKET-1:0] packet_t;

endpackage

// File: rtl/noc_fifo_ctrl.sv
// rtl/noc_fifo_ctrl.sv - circular FIFO pointers, occupancy and status flags
module noc_fifo_ctrl
  import noc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  localparam int PW       = $clog2(DEPTH),
  localparam int OW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [OW-1:0] occ,
  output logic          afull
);

  localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_AFULL = OW'(AFULL_LVL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_param
    $error("noc_fifo_ctrl: DEPTH must be a power of two >= 2 and AFULL_LVL in 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // Flags come only from registered occupancy, so ready never depends on out_ready.
  always_comb begin
    in_ready  = (occ_q != OCC_FULL);
    out_valid = (occ_q != '0);
    afull     = (occ_q >= OCC_AFULL);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_ptr    = wr_ptr_q;
    rd_ptr    = rd_ptr_q;
    occ       = occ_q;
  end

  // Next-state: pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all stored entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ_q == OCC_FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (occ_q == '0)));

endmodule

// File: rtl/noc_out_buffer.sv
// rtl/noc_out_buffer.sv - NoC router output-port packet buffer
module noc_out_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_PACKET-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_PACKET-1:0]    out_data,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       afull,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  packet_t          mem_q [DEPTH];
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  noc_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occ       (occ),
    .afull     (afull)
  );

  // Storage is not reset; entries are only meaningful while counted in occ.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= in_data;
  end

  // Head packet is read combinationally from registered storage (no bypass).
  always_comb begin
    out_data = mem_q[rd_ptr];
  end

  // Delivered-packet count advances on every pop and wraps without saturating.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    pkt_cnt = pkt_cnt_q;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

endmodule

// File: tb/tb_noc_out_buffer.sv
// tb/tb_noc_out_buffer.sv - directed self-checking bench for noc_out_buffer
module tb_noc_out_buffer;
  import noc_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_PACKET-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH_PACKET-1:0] out_data;
  logic [2:0]              occ;
  logic                    afull;
  logic [15:0]             pkt_cnt;

  int total;
  int bad;

  noc_out_buffer #(
    .DEPTH     (4),
    .AFULL_LVL (3),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ),
    .afull     (afull),
    .pkt_cnt   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", afull); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH_PACKET'(i);
      step();
      total++; if (occ !== 3'(i)) begin bad++; $display("FAIL fill_occ i=%0d got=%0d exp=%0d", i, occ, i); end
      total++; if (afull !== (i >= 3)) begin bad++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, afull, (i >= 3)); end
      total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, (i < 4)); end
      total++; if (out_data !== WIDTH_PACKET'(1)) begin bad++; $display("FAIL fill_head i=%0d got=%h exp=1", i, out_data); end
    end
    in_data = WIDTH_PACKET'(5);
    repeat (2) begin
      step();
      total++; if (occ !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_hold occ=%0d in_ready=%b exp occ=4 in_ready=0", occ, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== WIDTH_PACKET'(i)) begin bad++; $display("FAIL drain_data i=%0d valid=%b got=%h exp=%h", i, out_valid, out_data, i); end
      step();
    end
    out_ready = 1'b0;
    total++; if (pkt_cnt !== 16'd4) begin bad++; $display("FAIL drain_pkt_cnt got=%0d exp=4", pkt_cnt); end
    total++; if (out_valid !== 1'b0 || occ !== 3'd0) begin bad++; $display("FAIL drain_empty valid=%b occ=%0d exp valid=0 occ=0", out_valid, occ); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = WIDTH_PACKET'(32'h100 + k);
      if (k > 0) begin
        total++; if (out_valid !== 1'b1 || out_data !== WIDTH_PACKET'(32'h100 + k - 1)) begin bad++; $display("FAIL stream_data k=%0d valid=%b got=%h exp=%h", k, out_valid, out_data, 32'h100 + k - 1); end
        total++; if (occ !== 3'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_occ k=%0d occ=%0d in_ready=%b exp occ=1 in_ready=1", k, occ, in_ready); end
      end
      step();
    end
    in_valid = 1'b0;
    total++; if (out_data !== WIDTH_PACKET'(32'h113)) begin bad++; $display("FAIL stream_last got=%h exp=113", out_data); end
    step();
    out_ready = 1'b0;
    total++; if (occ !== 3'd0 || pkt_cnt !== 16'd24) begin bad++; $display("FAIL stream_end occ=%0d pkt_cnt=%0d exp occ=0 pkt_cnt=24", occ, pkt_cnt); end
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = WIDTH_PACKET'(32'h21 + i);
      step();
    end
    in_data = WIDTH_PACKET'(32'h25); out_ready = 1'b1;
    total++; if (in_ready !== 1'b0 || occ !== 3'd4) begin bad++; $display("FAIL full_pre in_ready=%b occ=%0d exp in_ready=0 occ=4", in_ready, occ); end
    step();
    total++; if (occ !== 3'd3 || in_ready !== 1'b1 || out_data !== WIDTH_PACKET'(32'h22)) begin bad++; $display("FAIL full_pop_only occ=%0d in_ready=%b head=%h exp 3 1 22", occ, in_ready, out_data); end
    step();
    in_valid = 1'b0;
    total++; if (occ !== 3'd3 || out_data !== WIDTH_PACKET'(32'h23)) begin bad++; $display("FAIL full_push_pop occ=%0d head=%h exp 3 23", occ, out_data); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_data !== WIDTH_PACKET'(32'h23 + i)) begin bad++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, out_data, 32'h23 + i); end
      step();
    end
    out_ready = 1'b0;
    total++; if (occ !== 3'd0 || pkt_cnt !== 16'd29) begin bad++; $display("FAIL full_end occ=%0d pkt_cnt=%0d exp occ=0 pkt_cnt=29", occ, pkt_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = WIDTH_PACKET'(32'h31); step();
    in_data = WIDTH_PACKET'(32'h32); step();
    in_valid = 1'b0;
    total++; if (occ !== 3'd2) begin bad++; $display("FAIL areset_pre occ=%0d exp=2", occ); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (occ !== 3'd0 || out_valid !== 1'b0 || pkt_cnt !== 16'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_now occ=%0d valid=%b cnt=%0d in_ready=%b exp 0 0 0 1", occ, out_valid, pkt_cnt, in_ready); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = WIDTH_PACKET'(32'hABC);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || occ !== 3'd1 || out_data !== WIDTH_PACKET'(32'hABC)) begin bad++; $display("FAIL areset_first valid=%b occ=%0d head=%h exp 1 1 abc", out_valid, occ, out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (pkt_cnt !== 16'd1 || occ !== 3'd0) begin bad++; $display("FAIL areset_deliver cnt=%0d occ=%0d exp 1 0", pkt_cnt, occ); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_simul();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
